// File: rtl/key_repeat.sv
// key_repeat
// Per-button front end for the move/rotate keys. A raw push-button pin is
// synchronised, debounced and turned into 1-clock press pulses. While the key
// stays held it produces a delayed auto-shift pulse and then auto-repeat pulses.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a level change
//   DAS_CYCLES       cycles from the press pulse to the first repeat pulse
//   ARR_CYCLES       cycles between later repeat pulses
//   ACTIVE_LOW       1: key_raw==0 means pressed; 0: active-high
//   REPEAT_EN        0: a single pulse per press, no auto-repeat
//
// Ports
//   clock          system clock
//   resetn         synchronous reset, active-low
//   key_raw        asynchronous raw button pin
//   edge_1clk      registered 1-clock press/repeat pulse
//   key_level      debounced level, 1 = pressed
//   repeat_active  1 while auto-repeat is running
module key_repeat #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DAS_CYCLES      = 10000000,
  parameter int ARR_CYCLES      = 2500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_EN       = 1
) (
  input  logic clock,
  input  logic resetn,
  input  logic key_raw,
  output logic edge_1clk,
  output logic key_level,
  output logic repeat_active
);

  localparam logic INACTIVE = (ACTIVE_LOW != 0);
  localparam int   DBW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int   RMAX     = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int   RW       = $clog2(RMAX + 1);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]  DAS_LAST = RW'(DAS_CYCLES - 1);
  localparam logic [RW-1:0]  ARR_LAST = RW'(ARR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DAS, REPEAT} state_t;

  state_t         state;
  logic           sync1, sync2;
  logic [DBW-1:0] db_cnt;
  logic [RW-1:0]  rcnt;

  logic pressed_s, mismatch, db_fire, level_nx;

  // The FSM looks at the level this edge will load, so the press pulse lands in
  // the same cycle key_level first reads 1 and release wins over any expiry.
  always_comb begin
    pressed_s = sync2 ^ INACTIVE;
    mismatch  = (pressed_s != key_level);
    db_fire   = mismatch && (db_cnt == DB_LAST);
    level_nx  = db_fire ? ~key_level : key_level;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1         <= INACTIVE;
      sync2         <= INACTIVE;
      db_cnt        <= '0;
      key_level     <= 1'b0;
      state         <= IDLE;
      rcnt          <= '0;
      edge_1clk     <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      sync1     <= key_raw;
      sync2     <= sync1;
      db_cnt    <= (!mismatch || db_fire) ? '0 : db_cnt + 1'b1;
      key_level <= level_nx;
      edge_1clk <= 1'b0;

      if (!level_nx) begin
        state         <= IDLE;
        rcnt          <= '0;
        repeat_active <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            edge_1clk <= 1'b1;
            rcnt      <= '0;
            state     <= DAS;
          end
          DAS: begin
            if (rcnt == DAS_LAST) begin
              // Without repeat, rcnt simply parks at its last value.
              if (REPEAT_EN != 0) begin
                edge_1clk     <= 1'b1;
                rcnt          <= '0;
                state         <= REPEAT;
                repeat_active <= 1'b1;
              end
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          REPEAT: begin
            if (rcnt == ARR_LAST) begin
              edge_1clk <= 1'b1;
              rcnt      <= '0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            rcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_repeat.sv
// tb_key_repeat
// Three key_repeat instances share one clock:
//   u0  DEBOUNCE=4 DAS=10 ARR=3 active-low, repeat on
//   u1  as u0 but repeat off
//   u2  active-high, ARR=1
// A timeline model derives every output from the raw-pin history and the
// press time; directed literals pin the model on the documented scenarios.
module tb_key_repeat;

  localparam int D   = 4;
  localparam int DAS = 10;
  localparam int NE  = 1024;

  int P_AL [3] = '{1, 1, 0};
  int P_REP[3] = '{1, 0, 1};
  int P_ARR[3] = '{3, 3, 1};

  logic       clock;
  logic       resetn;
  logic [2:0] raw, e, l, r;

  key_repeat #(.DEBOUNCE_CYCLES(D), .DAS_CYCLES(DAS), .ARR_CYCLES(3),
               .ACTIVE_LOW(1), .REPEAT_EN(1)) u0 (
    .clock(clock), .resetn(resetn), .key_raw(raw[0]),
    .edge_1clk(e[0]), .key_level(l[0]), .repeat_active(r[0]));

  key_repeat #(.DEBOUNCE_CYCLES(D), .DAS_CYCLES(DAS), .ARR_CYCLES(3),
               .ACTIVE_LOW(1), .REPEAT_EN(0)) u1 (
    .clock(clock), .resetn(resetn), .key_raw(raw[1]),
    .edge_1clk(e[1]), .key_level(l[1]), .repeat_active(r[1]));

  key_repeat #(.DEBOUNCE_CYCLES(D), .DAS_CYCLES(DAS), .ARR_CYCLES(1),
               .ACTIVE_LOW(0), .REPEAT_EN(1)) u2 (
    .clock(clock), .resetn(resetn), .key_raw(raw[2]),
    .edge_1clk(e[2]), .key_level(l[2]), .repeat_active(r[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int  total = 0;
  int  passed = 0;
  int  n = 0;
  int  last_rst = 0;
  int  last_tog[3] = '{0, 0, 0};
  int  t0[3] = '{0, 0, 0};
  bit  mlev[3] = '{0, 0, 0};
  bit  rawh[3][NE];
  bit  xe[3], xl[3], xr[3];

  task automatic chk(input string name, input logic act, input logic expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s @edge %0d: got %b, expected %b", name, n, act, expv);
  endtask

  task automatic chk_int(input string name, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s @edge %0d: got %0d, expected %0d", name, n, act, expv);
  endtask

  // Logical pressed value the debouncer sees at edge m: the pin as it was two
  // edges earlier, or released if a reset flushed the synchroniser since.
  function automatic bit seen(input int i, input int m);
    if (last_rst >= m - 2) return 1'b0;
    return rawh[i][m-2] ^ P_AL[i][0];
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 3; i++) rawh[i][n] = raw[i];
    if (!resetn) begin
      last_rst = n;
      for (int i = 0; i < 3; i++) begin
        mlev[i] = 1'b0; xe[i] = 1'b0; xl[i] = 1'b0; xr[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit ok;
        int d;
        // Accept a change once the last D observed samples all disagree with
        // the current level and none predates the last reset or toggle.
        ok = 1'b1;
        for (int k = 0; k < D; k++) begin
          int m;
          m = n - k;
          if (m <= last_rst || m <= last_tog[i]) ok = 1'b0;
          else if (seen(i, m) == mlev[i]) ok = 1'b0;
        end
        if (ok) begin
          mlev[i] = ~mlev[i];
          last_tog[i] = n;
          if (mlev[i]) t0[i] = n;
        end
        d = n - t0[i];
        xl[i] = mlev[i];
        xe[i] = mlev[i] && (d == 0 ||
                (P_REP[i] != 0 && d >= DAS && ((d - DAS) % P_ARR[i]) == 0));
        xr[i] = mlev[i] && P_REP[i] != 0 && d >= DAS;
      end
    end
  endtask

  // One clock: drive inputs (pressed levels per instance), advance the model on
  // the edge, then compare every output just after it.
  task automatic step(input bit rstn, input bit p0, input bit p1, input bit p2);
    resetn = rstn;
    raw[0] = p0 ^ P_AL[0][0];
    raw[1] = p1 ^ P_AL[1][0];
    raw[2] = p2 ^ P_AL[2][0];
    @(posedge clock);
    n++;
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.edge_1clk", i), e[i], xe[i]);
      chk($sformatf("u%0d.key_level", i), l[i], xl[i]);
      chk($sformatf("u%0d.repeat_active", i), r[i], xr[i]);
    end
  endtask

  initial begin
    int cnt;
    resetn = 1'b0;
    raw    = 3'b110;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("reset_outputs_zero", |{e, l, r}, 1'b0);
    repeat (5) step(1, 0, 0, 0);

    // 1: held press, DAS then ARR
    for (int i = 1; i <= 40; i++) begin
      step(1, 1, 0, 0);
      chk("t1_lit_edge", e[0], i inside {6, 16, 19, 22, 25, 28, 31, 34, 37, 40});
      chk("t1_lit_level", l[0], i >= 6);
      chk("t1_lit_repeat", r[0], i >= 16);
    end
    repeat (12) step(1, 0, 0, 0);

    // 2: short glitch is ignored
    repeat (3) step(1, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0);
      chk("t2_glitch_level", l[0], 1'b0);
      chk("t2_glitch_edge", e[0], 1'b0);
    end

    // 3: release 5 cycles after the press pulse, then re-press
    for (int i = 1; i <= 10; i++) begin
      step(1, 1, 0, 0);
      chk("t3_lit_edge", e[0], i == 6);
    end
    for (int j = 1; j <= 10; j++) begin
      step(1, 0, 0, 0);
      chk("t3_lit_fall", l[0], j < 6);
      chk("t3_no_release_pulse", e[0], 1'b0);
    end
    for (int i = 1; i <= 20; i++) begin
      step(1, 1, 0, 0);
      chk("t3_lit_repress", e[0], i inside {6, 16, 19});
    end
    repeat (12) step(1, 0, 0, 0);

    // 4: reset while in REPEAT with the key still held
    repeat (25) step(1, 1, 0, 0);
    chk("t4_in_repeat", r[0], 1'b1);
    step(0, 1, 0, 0);
    chk("t4_reset_edge", e[0], 1'b0);
    chk("t4_reset_level", l[0], 1'b0);
    chk("t4_reset_repeat", r[0], 1'b0);
    for (int j = 1; j <= 20; j++) begin
      step(1, 1, 0, 0);
      chk("t4_lit_edge", e[0], j inside {6, 16, 19});
    end
    repeat (12) step(1, 0, 0, 0);

    // 5: repeat disabled
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(1, 0, 1, 0);
      if (e[1]) cnt++;
      chk("t5_no_repeat", r[1], 1'b0);
    end
    chk_int("t5_single_pulse", cnt, 1);
    repeat (12) step(1, 0, 0, 0);

    // 6: active-high, ARR=1, release mid-run
    for (int i = 1; i <= 30; i++) begin
      step(1, 0, 0, 1);
      chk("t6_lit_edge", e[2], i == 6 || i >= 16);
    end
    for (int j = 1; j <= 10; j++) begin
      step(1, 0, 0, 0);
      chk("t6_lit_stop", e[2], j < 6);
      chk("t6_lit_level", l[2], j < 6);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
